// File: rtl/hazard_if.sv
// Hazard unit bus: pipeline register tags and enables in, stall/flush/forward controls out.
interface hazard_if;
  logic [4:0]  rs1d, rs2d;
  logic [4:0]  rs1e, rs2e, rde;
  logic [4:0]  rdm, rdw;
  logic        regwritee, regwritem, regwritew;
  logic [1:0]  resultsrce;
  logic        pcsrce;
  logic        memreqm;
  logic        dmem_ready;
  logic        stallf, stalld;
  logic        flushd, flushe;
  logic        freeze;
  logic [1:0]  forwardae, forwardbe;
  logic [31:0] stall_cnt;
  logic        mem_timeout;

  modport master (
    output rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
           regwritee, regwritem, regwritew, resultsrce, pcsrce, memreqm, dmem_ready,
    input  stallf, stalld, flushd, flushe, freeze, forwardae, forwardbe, stall_cnt, mem_timeout
  );

  modport slave (
    input  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
           regwritee, regwritem, regwritew, resultsrce, pcsrce, memreqm, dmem_ready,
    output stallf, stalld, flushd, flushe, freeze, forwardae, forwardbe, stall_cnt, mem_timeout
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use/RAW stalls, branch flushes, EX forwarding, data-memory wait FSM.
// Build macro FORWARD_EN enables MEM/WB forwarding; without it RAW hazards from EX/MEM stall instead.
//
// state     | meaning
// IDLE      | no outstanding data-memory wait
// MEM_WAIT  | MEM access pending, pipeline frozen, wait counter running
module hazard_unit #(
  parameter int TIMEOUT = 255
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave hz
);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;
  localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT);

`ifdef FORWARD_EN
  localparam logic FWD_ON = 1'b1;
`else
  localparam logic FWD_ON = 1'b0;
`endif

  logic [0:0]  state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic        freeze_raw;
  logic        load_use;
  logic        raw_stall;
  logic [1:0]  fwd_a, fwd_b;
  logic        stall_out;

  always_comb begin
    freeze_raw = hz.memreqm & ~hz.dmem_ready;
    load_use   = (hz.resultsrce == 2'b01) & (hz.rde != 5'd0) &
                 ((hz.rde == hz.rs1d) | (hz.rde == hz.rs2d));

    // Without forwarding, any pending EX/MEM write to an ID source must drain first.
    raw_stall  = ~FWD_ON & (
                   (hz.regwritee & (hz.rde != 5'd0) & ((hz.rde == hz.rs1d) | (hz.rde == hz.rs2d))) |
                   (hz.regwritem & (hz.rdm != 5'd0) & ((hz.rdm == hz.rs1d) | (hz.rdm == hz.rs2d))));

    fwd_a = 2'b00;
    if (hz.regwritem & (hz.rdm != 5'd0) & (hz.rdm == hz.rs1e))      fwd_a = 2'b10;
    else if (hz.regwritew & (hz.rdw != 5'd0) & (hz.rdw == hz.rs1e)) fwd_a = 2'b01;

    fwd_b = 2'b00;
    if (hz.regwritem & (hz.rdm != 5'd0) & (hz.rdm == hz.rs2e))      fwd_b = 2'b10;
    else if (hz.regwritew & (hz.rdw != 5'd0) & (hz.rdw == hz.rs2e)) fwd_b = 2'b01;
  end

  always_comb begin
    hz.stallf    = 1'b0;
    hz.stalld    = 1'b0;
    hz.flushd    = 1'b0;
    hz.flushe    = 1'b0;
    hz.freeze    = 1'b0;
    hz.forwardae = 2'b00;
    hz.forwardbe = 2'b00;
    if (!rst) begin
      hz.freeze    = freeze_raw;
      hz.forwardae = FWD_ON ? fwd_a : 2'b00;
      hz.forwardbe = FWD_ON ? fwd_b : 2'b00;
      // Freeze holds branch/load-use decisions until the memory access completes.
      if (freeze_raw) begin
        hz.stallf = 1'b1;
        hz.stalld = 1'b1;
      end else if (hz.pcsrce) begin
        hz.flushd = 1'b1;
        hz.flushe = 1'b1;
      end else if (load_use | raw_stall) begin
        hz.stallf = 1'b1;
        hz.stalld = 1'b1;
        hz.flushe = 1'b1;
      end
    end
    stall_out = hz.stallf;
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (freeze_raw) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd0;
        end
      end
      ST_MEM_WAIT: begin
        if (wait_cnt_q != TIMEOUT_VAL) wait_cnt_d = wait_cnt_q + 8'd1;
        if (wait_cnt_d == TIMEOUT_VAL) mem_timeout_d = 1'b1;
        if (hz.dmem_ready | ~hz.memreqm) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    stall_cnt_d = stall_cnt_q;
    if (stall_out && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;

    hz.stall_cnt   = stall_cnt_q;
    hz.mem_timeout = mem_timeout_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

endmodule
